// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundles the two requester channels and the shared-ALU channel of alu_arbiter.
//   Requester side : req0/req1, op1_x/op2_x, opcode0/1 (to arbiter);
//                    ack0/1, res0/1, flags0/1 {v,n,z}, busy (from arbiter).
//   ALU side       : alu_op1/alu_op2/alu_opcode (from arbiter);
//                    alu_res, alu_z/alu_n/alu_v (from the combinational ALU).
//   slave  modport : seen by the arbiter.
//   master modport : seen by the environment (requesters and ALU).
interface alu_arbiter_if;
  logic        req0;
  logic        req1;
  logic [31:0] op1_0;
  logic [31:0] op2_0;
  logic [31:0] op1_1;
  logic [31:0] op2_1;
  logic [3:0]  opcode0;
  logic [3:0]  opcode1;
  logic        ack0;
  logic        ack1;
  logic [31:0] res0;
  logic [31:0] res1;
  logic [2:0]  flags0;
  logic [2:0]  flags1;
  logic        busy;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_res;
  logic        alu_z;
  logic        alu_n;
  logic        alu_v;

  modport slave (
    input  req0, req1, op1_0, op2_0, op1_1, op2_1, opcode0, opcode1,
    input  alu_res, alu_z, alu_n, alu_v,
    output ack0, ack1, res0, res1, flags0, flags1, busy,
    output alu_op1, alu_op2, alu_opcode
  );

  modport master (
    output req0, req1, op1_0, op2_0, op1_1, op2_1, opcode0, opcode1,
    output alu_res, alu_z, alu_n, alu_v,
    input  ack0, ack1, res0, res1, flags0, flags1, busy,
    input  alu_op1, alu_op2, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Sequence per operation: IDLE (arbitrate + latch) -> EXEC (capture result) -> DONE -> IDLE,
//   with the ack pulse registered on the DONE->IDLE edge (ack two edges after the grant edge).
// Ports:
//   CLK  : clock, rising edge
//   nRST : asynchronous active-low reset
//   bus  : alu_arbiter_if.slave (requester channels, results/flags/acks, busy, ALU channel)
// Configuration:
//   ALU_ARB_RR_EN defined   -> round-robin on ties (requester not granted last wins)
//   ALU_ARB_RR_EN undefined -> requester 0 always wins ties
module alu_arbiter (
  input logic         CLK,
  input logic         nRST,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e      state_q, state_d;

  logic        id_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [3:0]  opcode_q;
  logic [31:0] res0_q;
  logic [31:0] res1_q;
  logic [2:0]  flags0_q;
  logic [2:0]  flags1_q;
  logic        ack0_q;
  logic        ack1_q;

  logic        any_req;
  logic        grant_id;

  assign any_req = bus.req0 | bus.req1;

`ifdef ALU_ARB_RR_EN
  logic last_q;

  // On a tie the requester not served last wins; otherwise the sole requester wins.
  always_comb begin
    if (bus.req0 && bus.req1) begin
      grant_id = ~last_q;
    end else begin
      grant_id = bus.req1;
    end
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q <= 1'b1;
    end else if (state_q == StDone) begin
      last_q <= id_q;
    end
  end
`else
  // Fixed priority: requester 0 wins whenever it asks.
  always_comb begin
    grant_id = ~bus.req0;
  end
`endif

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (any_req) state_d = StExec;
      StExec:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: operands latched only at the grant edge, so later operand changes and
  // dropped requests cannot disturb an operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      id_q     <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      opcode_q <= '0;
      res0_q   <= '0;
      res1_q   <= '0;
      flags0_q <= '0;
      flags1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (any_req) begin
            id_q     <= grant_id;
            op1_q    <= grant_id ? bus.op1_1   : bus.op1_0;
            op2_q    <= grant_id ? bus.op2_1   : bus.op2_0;
            opcode_q <= grant_id ? bus.opcode1 : bus.opcode0;
          end
        end
        StExec: begin
          if (id_q) begin
            res1_q   <= bus.alu_res;
            flags1_q <= {bus.alu_v, bus.alu_n, bus.alu_z};
          end else begin
            res0_q   <= bus.alu_res;
            flags0_q <= {bus.alu_v, bus.alu_n, bus.alu_z};
          end
        end
        StDone: begin
          ack0_q <= ~id_q;
          ack1_q <= id_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs: all registered, ALU driven only from latched values.
  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.ack0       = ack0_q;
    bus.ack1       = ack1_q;
    bus.res0       = res0_q;
    bus.res1       = res1_q;
    bus.flags0     = flags0_q;
    bus.flags1     = flags1_q;
    bus.alu_op1    = op1_q;
    bus.alu_op2    = op2_q;
    bus.alu_opcode = opcode_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, expected results pushed into a scoreboard queue by
// the stimulus thread and popped/compared by a monitor whenever an ack appears.
module tb_alu_arbiter;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic [2:0]  flags;
  } sb_entry_t;

  logic CLK;
  logic nRST;
  alu_arbiter_if bus ();

  alu_arbiter dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shared combinational ALU model
  logic [31:0] a, b, r;
  logic        v;
  always_comb begin
    a = bus.alu_op1;
    b = bus.alu_op2;
    r = '0;
    v = 1'b0;
    case (bus.alu_opcode)
      OpAdd: begin
        r = a + b;
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OpSub: begin
        r = a - b;
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = a & b;
    endcase
    bus.alu_res = r;
    bus.alu_v   = v;
    bus.alu_n   = r[31];
    bus.alu_z   = (r == 32'd0);
  end

  int checks = 0;
  int errors = 0;
  sb_entry_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each ack and checks the non-granted side held its values.
  logic [31:0] m_res0, m_res1;
  logic [2:0]  m_flags0, m_flags1;
  sb_entry_t   e;

  always @(negedge CLK) begin
    if (!nRST) begin
      m_res0 = '0; m_res1 = '0; m_flags0 = '0; m_flags1 = '0;
    end else if (bus.ack0 || bus.ack1) begin
      check("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(bus.ack1), 32'hdead);
      end else begin
        e = sb.pop_front();
        check("ack_id", 32'(bus.ack1), 32'(e.id));
        if (e.id) begin
          check("res1", bus.res1, e.res);
          check("flags1", 32'(bus.flags1), 32'(e.flags));
          check("res0_hold", bus.res0, m_res0);
          check("flags0_hold", 32'(bus.flags0), 32'(m_flags0));
          m_res1 = e.res; m_flags1 = e.flags;
        end else begin
          check("res0", bus.res0, e.res);
          check("flags0", 32'(bus.flags0), 32'(e.flags));
          check("res1_hold", bus.res1, m_res1);
          check("flags1_hold", 32'(bus.flags1), 32'(m_flags1));
          m_res0 = e.res; m_flags0 = e.flags;
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge CLK);
      if (bus.ack0 || bus.ack1) seen++;
    end
    check("ack_count", 32'(seen), 32'(n));
  endtask

  task automatic issue(input logic id, input logic [31:0] op1, input logic [31:0] op2,
                       input logic [3:0] opc, input logic [31:0] exp_res,
                       input logic [2:0] exp_flags);
    @(negedge CLK);
    if (id) begin
      bus.req1 = 1'b1; bus.op1_1 = op1; bus.op2_1 = op2; bus.opcode1 = opc;
    end else begin
      bus.req0 = 1'b1; bus.op1_0 = op1; bus.op2_0 = op2; bus.opcode0 = opc;
    end
    sb.push_back('{id, exp_res, exp_flags});
    @(posedge CLK);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_acks(1, 10);
  endtask

  initial begin
    nRST = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op1_0 = '0; bus.op2_0 = '0; bus.op1_1 = '0; bus.op2_1 = '0;
    bus.opcode0 = '0; bus.opcode1 = '0;

    // Reset state
    #12;
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_res0", bus.res0, 32'd0);
    check("rst_res1", bus.res1, 32'd0);
    check("rst_flags0", 32'(bus.flags0), 32'd0);
    check("rst_flags1", 32'(bus.flags1), 32'd0);
    check("rst_alu_op1", bus.alu_op1, 32'd0);
    check("rst_alu_op2", bus.alu_op2, 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // ADD 5+3 with latency/busy checks; op1_0 changed after the grant must be ignored
    @(negedge CLK);
    bus.req0 = 1'b1; bus.op1_0 = 32'd5; bus.op2_0 = 32'd3; bus.opcode0 = OpAdd;
    sb.push_back('{1'b0, 32'd8, 3'b000});
    @(posedge CLK);
    #1;
    bus.req0 = 1'b0;
    bus.op1_0 = 32'd9;
    @(negedge CLK);
    check("busy_exec", 32'(bus.busy), 32'd1);
    check("alu_op1_latched", bus.alu_op1, 32'd5);
    check("ack0_early1", 32'(bus.ack0), 32'd0);
    @(negedge CLK);
    check("busy_done", 32'(bus.busy), 32'd1);
    check("ack0_early2", 32'(bus.ack0), 32'd0);
    check("res0_captured", bus.res0, 32'd8);
    @(negedge CLK);
    check("ack0_at_k2", 32'(bus.ack0), 32'd1);
    check("busy_idle", 32'(bus.busy), 32'd0);
    @(negedge CLK);
    check("ack0_one_cycle", 32'(bus.ack0), 32'd0);

    // Signed overflow: 7FFFFFFF+1
    issue(1'b0, 32'h7fff_ffff, 32'd1, OpAdd, 32'h8000_0000, 3'b110);
    // Requester 1 SUB 0-1; res0 must hold
    issue(1'b1, 32'd0, 32'd1, OpSub, 32'hffff_ffff, 3'b010);
    check("res0_still", bus.res0, 32'h8000_0000);

    // Continuous tie: ADD 1+1 on requester 0, SUB 7-7 on requester 1
    @(negedge CLK);
    bus.req0 = 1'b1; bus.op1_0 = 32'd1; bus.op2_0 = 32'd1; bus.opcode0 = OpAdd;
    bus.req1 = 1'b1; bus.op1_1 = 32'd7; bus.op2_1 = 32'd7; bus.opcode1 = OpSub;
`ifdef ALU_ARB_RR_EN
    sb.push_back('{1'b0, 32'd2, 3'b000});
    sb.push_back('{1'b1, 32'd0, 3'b001});
    sb.push_back('{1'b0, 32'd2, 3'b000});
`else
    sb.push_back('{1'b0, 32'd2, 3'b000});
    sb.push_back('{1'b0, 32'd2, 3'b000});
    sb.push_back('{1'b0, 32'd2, 3'b000});
`endif
    wait_acks(3, 30);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset during EXEC aborts the operation
    @(negedge CLK);
    bus.req0 = 1'b1; bus.op1_0 = 32'd2; bus.op2_0 = 32'd3; bus.opcode0 = OpAdd;
    bus.req1 = 1'b1; bus.op1_1 = 32'd4; bus.op2_1 = 32'd4; bus.opcode1 = OpAdd;
    @(posedge CLK);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_res0", bus.res0, 32'd0);
    check("abort_res1", bus.res1, 32'd0);
    check("abort_alu_op1", bus.alu_op1, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("abort_no_ack", 32'({bus.ack1, bus.ack0}), 32'd0);
      check("abort_idle", 32'(bus.busy), 32'd0);
    end

    // First tie after reset goes to requester 0
    @(negedge CLK);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    sb.push_back('{1'b0, 32'd5, 3'b000});
    @(posedge CLK);
    #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_acks(1, 10);
    check("res1_after_reset", bus.res1, 32'd0);

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have: CLK  in  1  system clock, rising-edge.
REQ-002 The block SHALL have: nRST  in  1  reset, asynchronous, active-low.
REQ-003 The block SHALL have: req0 / req1  in  1 each  requester 0/1 operation request.
REQ-004 The block SHALL have: op1_0, op2_0, op1_1, op2_1  in  32 each  requester operands.
REQ-005 The block SHALL have: opcode0 / opcode1  in  4 each  requester ALU opcode.
REQ-006 The block SHALL have: ack0 / ack1  out  1 each  one-cycle completion pulse.
REQ-007 The block SHALL have: res0 / res1  out  32 each  registered result per requester.
REQ-008 The block SHALL have: flags0 / flags1  out  3 each  registered {v,n,z} per requester.
REQ-009 The block SHALL have: busy  out  1  high in any state other than IDLE.
REQ-010 The block SHALL have: alu_op1, alu_op2  out  32 each, and alu_opcode  out  4, driving the shared ALU.
REQ-011 The block SHALL have: alu_res  in  32, and alu_z, alu_n, alu_v  in  1 each, from the shared combinational ALU.

Function
REQ-012 The block SHALL implement FSM states IDLE, EXEC, DONE, encoded in two bits.
REQ-013 In IDLE with no request, the block SHALL stay in IDLE and leave all registers unchanged.
REQ-014 In IDLE with at least one request, the block SHALL latch the winner's id, operands and opcode into internal registers, then go to EXEC.
REQ-015 Arbitration with both requests high SHALL grant the requester not granted last; with one request high, that requester SHALL win.
REQ-016 alu_op1, alu_op2 and alu_opcode SHALL be driven from the latched registers only; they SHALL NOT depend combinationally on requester inputs.
REQ-017 In EXEC, the block SHALL capture alu_res into res<id> and {alu_v, alu_n, alu_z} into flags<id>, then go to DONE.
REQ-018 In DONE, the block SHALL assert ack<id> for exactly one cycle, update the last-granted id, then go to IDLE.
REQ-019 Latency: with req sampled at rising edge k, ack SHALL be high from edge k+2 to edge k+3; throughput SHALL be one operation per 3 cycles.
REQ-020 Requesters SHALL hold operands until ack; operand changes after the grant edge SHALL be ignored.
REQ-021 A req still high in IDLE after its ack SHALL be treated as a new request, subject to arbitration.
REQ-022 The result and flags of the non-granted requester SHALL hold their previous values.
REQ-023 ack0 and ack1 SHALL never be high in the same cycle.
REQ-024 A req dropped while its operation is in EXEC or DONE SHALL NOT cancel the operation; ack SHALL still be issued.

Reset
REQ-025 While nRST is low, the block SHALL set: state IDLE; ack0 and ack1 low; busy low; res0, res1, flags0, flags1 zero; latched operands and opcode zero.
REQ-026 While nRST is low, the block SHALL set last-granted to 1, so requester 0 wins the first tie.
REQ-027 A reset asserted in EXEC or DONE SHALL abort the operation with no ack and no result update.

Configuration
REQ-028 ALU_ARB_RR_EN SHALL select the arbitration policy.
REQ-029 With ALU_ARB_RR_EN defined, the block SHALL use round-robin arbitration per REQ-015.
REQ-030 Without ALU_ARB_RR_EN, requester 0 SHALL always win ties and last-granted SHALL be unused; all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: after reset, req0=1 with op1_0=5, op2_0=3, opcode ADD -> ack0 at edge+2, res0=8, flags0=000, busy high for 2 cycles.
REQ-032 Scenario: req0 and req1 both high continuously, ADD 1+1 and SUB 7-7 -> ack0, ack1, ack0 alternate every 3 cycles; res1=0 with flags1 z=1 (round-robin build); the fixed-priority build acks only requester 0.
REQ-033 Scenario: req1 SUB 0-1 -> res1=FFFFFFFF with flags1 n=1; res0 remains unchanged.
REQ-034 Scenario: req0 ADD 7FFFFFFF+1 -> res0=80000000, flags0 v=1, n=1.
REQ-035 Scenario: op1_0 changed to 9 the cycle after the grant -> result still uses the latched 5.
REQ-036 Scenario: nRST pulsed low during EXEC -> no ack; res0=0; state IDLE; the next tie goes to requester 0.
